// File: rtl/regfile_scan_checker.sv
// -----------------------------------------------------------------------------
// regfile_scan_checker
//
// Self-checking harness that sits between a processor, its register file and
// an expected-value ROM.
//   1. On start, holds the processor in reset for one cycle.
//   2. Lets the processor run for a programmable number of cycles. Every
//      register write (except to r0) is captured into a trace FIFO together
//      with its cycle timestamp.
//   3. Takes over the regfile's read port A and scans every register against
//      the ROM, counting mismatches and recording the lowest failing index.
//
// Ports
//   clock, reset              system clock, synchronous active-high reset
//   start, num_cycles         begin a run (accepted in IDLE/DONE only) + budget
//   cpu_reset                 reset to processor/regfile (one cycle per run)
//   cpu_rs1 / rs1_out / regA  read port A pass-through / hijack during scan
//   exp_addr / exp_data       expected ROM (exp_data is a registered read)
//   mon_rwe/mon_rd/mon_data   processor register-write monitor
//   trace_*                   trace FIFO head, pop and sticky overflow flag
//   test_mode, busy, done     status
//   pass, error_count,
//   first_fail_reg            scan result
//   dbg_state                 current FSM state encoding
//
// Handshake: trace_valid/trace_pop follow valid/ready semantics -- an entry is
// consumed on a rising clock edge where trace_valid and trace_pop are both
// high; trace_pop while trace_valid is low is ignored.
// -----------------------------------------------------------------------------
module regfile_scan_checker #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int CYCLE_W     = 10,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CYCLE_W-1:0]    num_cycles,
  output logic                  cpu_reset,
  input  logic [REG_ADDR_W-1:0] cpu_rs1,
  output logic [REG_ADDR_W-1:0] rs1_out,
  input  logic [DATA_WIDTH-1:0] regA,
  output logic [REG_ADDR_W-1:0] exp_addr,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic                  mon_rwe,
  input  logic [REG_ADDR_W-1:0] mon_rd,
  input  logic [DATA_WIDTH-1:0] mon_data,
  input  logic                  trace_pop,
  output logic                  trace_valid,
  output logic [CYCLE_W-1:0]    trace_cycle,
  output logic [REG_ADDR_W-1:0] trace_rd,
  output logic [DATA_WIDTH-1:0] trace_data,
  output logic                  trace_overflow,
  output logic                  test_mode,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [REG_ADDR_W:0]   error_count,
  output logic [REG_ADDR_W-1:0] first_fail_reg,
  output logic [2:0]            dbg_state
);

  localparam int PTR_W   = $clog2(TRACE_DEPTH);
  localparam int ENTRY_W = CYCLE_W + REG_ADDR_W + DATA_WIDTH;

  localparam logic [CYCLE_W-1:0]    CYC_ONE  = CYCLE_W'(1);
  localparam logic [REG_ADDR_W-1:0] IDX_ONE  = REG_ADDR_W'(1);
  localparam logic [REG_ADDR_W-1:0] IDX_LAST = REG_ADDR_W'(NUM_REGS - 1);
  localparam logic [REG_ADDR_W:0]   ERR_ONE  = (REG_ADDR_W + 1)'(1);
  localparam logic [PTR_W:0]        PTR_ONE  = (PTR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RESET_CPU  = 3'd1,
    S_RUN        = 3'd2,
    S_SCAN_ISSUE = 3'd3,
    S_SCAN_CHECK = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CYCLE_W-1:0]    r_num_cycles;
  logic [CYCLE_W-1:0]    r_cycle_cnt;
  logic [REG_ADDR_W-1:0] r_scan_idx;
  logic [REG_ADDR_W:0]   r_error_count;
  logic [REG_ADDR_W-1:0] r_first_fail;

  logic w_start_ok;
  logic w_run_last;
  logic w_scan_last;
  logic w_mismatch;

  // Trace FIFO storage; pointers carry one extra wrap bit to tell full/empty.
  logic [ENTRY_W-1:0] r_mem [TRACE_DEPTH];
  logic [PTR_W:0]     r_wr_ptr;
  logic [PTR_W:0]     r_rd_ptr;
  logic               r_overflow;

  logic w_empty;
  logic w_full;
  logic w_push_req;
  logic w_push_ok;
  logic w_pop_ok;
  logic [ENTRY_W-1:0] w_head;

  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  // Only evaluated in RUN, where the latched budget is known to be non-zero.
  assign w_run_last  = (r_cycle_cnt == (r_num_cycles - CYC_ONE));
  assign w_scan_last = (r_scan_idx == IDX_LAST);
  assign w_mismatch  = (regA != exp_data);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_ok) w_state_next = S_RESET_CPU;
      end
      S_RESET_CPU: begin
        // A zero budget skips RUN entirely.
        w_state_next = (r_num_cycles == '0) ? S_SCAN_ISSUE : S_RUN;
      end
      S_RUN: begin
        if (w_run_last) w_state_next = S_SCAN_ISSUE;
      end
      S_SCAN_ISSUE: begin
        w_state_next = S_SCAN_CHECK;
      end
      S_SCAN_CHECK: begin
        w_state_next = w_scan_last ? S_DONE : S_SCAN_ISSUE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Run counter and scan datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_num_cycles  <= '0;
      r_cycle_cnt   <= '0;
      r_scan_idx    <= '0;
      r_error_count <= '0;
      r_first_fail  <= '0;
    end else begin
      if (w_start_ok) begin
        r_num_cycles  <= num_cycles;
        r_scan_idx    <= '0;
        r_error_count <= '0;
        r_first_fail  <= '0;
      end
      case (r_state)
        S_RESET_CPU: begin
          r_cycle_cnt <= '0;
        end
        S_RUN: begin
          r_cycle_cnt <= r_cycle_cnt + CYC_ONE;
        end
        S_SCAN_CHECK: begin
          // exp_data was addressed in SCAN_ISSUE, so it is valid this cycle.
          if (w_mismatch) begin
            r_error_count <= r_error_count + ERR_ONE;
            if (r_error_count == '0) r_first_fail <= r_scan_idx;
          end
          if (!w_scan_last) r_scan_idx <= r_scan_idx + IDX_ONE;
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Trace FIFO
  // ---------------------------------------------------------------------------
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_push_req = (r_state == S_RUN) && mon_rwe && (mon_rd != '0);
  assign w_pop_ok   = trace_pop && !w_empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO is accepted.
  assign w_push_ok  = w_push_req && (!w_full || w_pop_ok);

  always_ff @(posedge clock) begin
    if (reset || w_start_ok) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push_req && !w_push_ok) r_overflow <= 1'b1;
    end
  end

  // Storage is not reset; the head is masked by trace_valid instead.
  always_ff @(posedge clock) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= {r_cycle_cnt, mon_rd, mon_data};
    end
  end

  assign w_head = r_mem[r_rd_ptr[PTR_W-1:0]];

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign trace_valid    = !w_empty;
  assign trace_cycle    = trace_valid ? w_head[ENTRY_W-1 -: CYCLE_W] : '0;
  assign trace_rd       = trace_valid ? w_head[DATA_WIDTH +: REG_ADDR_W] : '0;
  assign trace_data     = trace_valid ? w_head[DATA_WIDTH-1:0] : '0;
  assign trace_overflow = r_overflow;

  assign cpu_reset      = (r_state == S_RESET_CPU);
  assign test_mode      = (r_state == S_SCAN_ISSUE) || (r_state == S_SCAN_CHECK);
  assign busy           = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done           = (r_state == S_DONE);
  assign pass           = done && (r_error_count == '0);
  assign error_count    = r_error_count;
  assign first_fail_reg = r_first_fail;
  assign rs1_out        = test_mode ? r_scan_idx : cpu_rs1;
  assign exp_addr       = r_scan_idx;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_regfile_scan_checker.sv
// -----------------------------------------------------------------------------
// tb_regfile_scan_checker
//
// Drives regfile_scan_checker (trace depth 4) with a behavioural regfile,
// a registered expected-value ROM and a processor write monitor. A queue
// models the trace FIFO; mismatch results are recomputed from the arrays.
// -----------------------------------------------------------------------------
module tb_regfile_scan_checker;

  localparam int DW    = 32;
  localparam int NR    = 32;
  localparam int AW    = 5;
  localparam int CW    = 10;
  localparam int DEPTH = 4;
  localparam int EW    = CW + AW + DW;

  // clock / reset
  logic clock;
  logic reset;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic          start;
  logic [CW-1:0] num_cycles;
  logic          cpu_reset;
  logic [AW-1:0] cpu_rs1;
  logic [AW-1:0] rs1_out;
  logic [DW-1:0] regA;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic          mon_rwe;
  logic [AW-1:0] mon_rd;
  logic [DW-1:0] mon_data;
  logic          trace_pop;
  logic          trace_valid;
  logic [CW-1:0] trace_cycle;
  logic [AW-1:0] trace_rd;
  logic [DW-1:0] trace_data;
  logic          trace_overflow;
  logic          test_mode;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW:0]   error_count;
  logic [AW-1:0] first_fail_reg;
  logic [2:0]    dbg_state;

  regfile_scan_checker #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .REG_ADDR_W(AW),
    .CYCLE_W(CW), .TRACE_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
    .cpu_reset(cpu_reset), .cpu_rs1(cpu_rs1), .rs1_out(rs1_out), .regA(regA),
    .exp_addr(exp_addr), .exp_data(exp_data), .mon_rwe(mon_rwe),
    .mon_rd(mon_rd), .mon_data(mon_data), .trace_pop(trace_pop),
    .trace_valid(trace_valid), .trace_cycle(trace_cycle),
    .trace_rd(trace_rd), .trace_data(trace_data),
    .trace_overflow(trace_overflow), .test_mode(test_mode), .busy(busy),
    .done(done), .pass(pass), .error_count(error_count),
    .first_fail_reg(first_fail_reg), .dbg_state(dbg_state)
  );

  // behavioural regfile (combinational read) and ROM (registered read)
  logic [DW-1:0] rf  [NR];
  logic [DW-1:0] rom [NR];
  assign regA = rf[rs1_out];
  always @(posedge clock) exp_data <= rom[exp_addr];

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];
  bit            exp_ovf;

  // per-RUN-cycle stimulus plan
  logic          plan_rwe  [64];
  logic [AW-1:0] plan_rd   [64];
  logic [DW-1:0] plan_data [64];
  logic          plan_pop  [64];

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_plan();
    for (int k = 0; k < 64; k++) begin
      plan_rwe[k]  = 1'b0;
      plan_rd[k]   = '0;
      plan_data[k] = '0;
      plan_pop[k]  = 1'b0;
    end
  endtask

  task automatic random_plan(input int pop_pct);
    for (int k = 0; k < 64; k++) begin
      plan_rwe[k]  = ($urandom_range(0, 99) < 60);
      plan_rd[k]   = AW'($urandom_range(0, NR - 1));
      plan_data[k] = $urandom;
      plan_pop[k]  = ($urandom_range(0, 99) < pop_pct);
    end
  endtask

  task automatic load_arrays(input int nflips);
    int idx;
    for (int i = 0; i < NR; i++) begin
      rf[i]  = $urandom;
      rom[i] = rf[i];
    end
    for (int f = 0; f < nflips; f++) begin
      idx = $urandom_range(0, NR - 1);
      rom[idx] = rom[idx] ^ (32'h1 << $urandom_range(0, DW - 1));
    end
  endtask

  // Runs one complete start..done sequence, checking the trace head every
  // RUN cycle and the scan result at the end.
  task automatic do_run(input int n, input bit noise);
    int lat;
    bit got;
    bit pop_ok;
    int exp_err;
    int exp_first;
    start      = 1'b1;
    num_cycles = CW'(n);
    trace_pop  = 1'b0;
    mon_rwe    = 1'b0;
    cyc();
    start = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    checks++;
    if (cpu_reset !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_cpu_phase: cpu_reset=%b busy=%b done=%b, want 1 1 0", cpu_reset, busy, done);
    end
    // a write while the CPU is in reset must not be traced
    mon_rwe  = 1'b1;
    mon_rd   = AW'($urandom_range(1, NR - 1));
    mon_data = $urandom;
    cyc();
    lat = 1;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (cpu_reset !== 1'b0 || test_mode !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL run_status k=%0d: cpu_reset=%b test_mode=%b busy=%b, want 0 0 1", k, cpu_reset, test_mode, busy);
      end
      mon_rwe   = plan_rwe[k];
      mon_rd    = plan_rd[k];
      mon_data  = plan_data[k];
      trace_pop = plan_pop[k];
      start     = noise && (k == 1);
      num_cycles = CW'($urandom_range(0, 100));
      checks++;
      if (exp_q.size() > 0) begin
        if (trace_valid !== 1'b1 || {trace_cycle, trace_rd, trace_data} !== exp_q[0]) begin
          errors++;
          $display("FAIL run_head k=%0d: valid=%b head=%h, want 1 %h", k, trace_valid, {trace_cycle, trace_rd, trace_data}, exp_q[0]);
        end
      end else if (trace_valid !== 1'b0) begin
        errors++;
        $display("FAIL run_head k=%0d: valid=%b, want 0", k, trace_valid);
      end
      // model: pop frees a slot before the push of the same cycle
      pop_ok = plan_pop[k] && (exp_q.size() > 0);
      if (pop_ok) void'(exp_q.pop_front());
      if (plan_rwe[k] && plan_rd[k] != '0) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({CW'(k), plan_rd[k], plan_data[k]});
        else exp_ovf = 1'b1;
      end
      cyc();
      lat++;
    end
    mon_rwe   = 1'b0;
    trace_pop = 1'b0;
    start     = 1'b0;
    cpu_rs1   = 5'd17;
    checks++;
    if (test_mode !== 1'b1 || rs1_out !== 5'd0 || exp_addr !== 5'd0 || cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL scan_entry: test_mode=%b rs1_out=%0d exp_addr=%0d cpu_reset=%b, want 1 0 0 0", test_mode, rs1_out, exp_addr, cpu_reset);
    end
    if (noise) begin
      start = 1'b1;
      cyc();
      lat++;
      start = 1'b0;
    end
    got = 1'b0;
    while (!got && lat < 400) begin
      cyc();
      lat++;
      got = (done === 1'b1);
    end
    checks++;
    if (!got || lat != n + 65) begin
      errors++;
      $display("FAIL done_latency: got=%b cycles=%0d, want done after %0d", got, lat, n + 65);
    end
    exp_err = 0;
    exp_first = 0;
    for (int i = NR - 1; i >= 0; i--) begin
      if (rf[i] != rom[i]) begin
        exp_err++;
        exp_first = i;
      end
    end
    checks++;
    if (error_count !== (AW + 1)'(exp_err) || pass !== (exp_err == 0) || first_fail_reg !== AW'(exp_first)) begin
      errors++;
      $display("FAIL scan_result: errs=%0d pass=%b first=%0d, want %0d %b %0d", error_count, pass, first_fail_reg, exp_err, exp_err == 0, exp_first);
    end
    checks++;
    if (busy !== 1'b0 || test_mode !== 1'b0 || rs1_out !== cpu_rs1 || trace_overflow !== exp_ovf) begin
      errors++;
      $display("FAIL done_status: busy=%b test_mode=%b rs1_out=%0d ovf=%b, want 0 0 %0d %b", busy, test_mode, rs1_out, trace_overflow, cpu_rs1, exp_ovf);
    end
  endtask

  // Pops every remaining trace entry and compares it in order.
  task automatic drain_trace(input string name);
    while (exp_q.size() > 0) begin
      checks++;
      if (trace_valid !== 1'b1 || {trace_cycle, trace_rd, trace_data} !== exp_q[0]) begin
        errors++;
        $display("FAIL %s_pop: valid=%b head=%h, want 1 %h", name, trace_valid, {trace_cycle, trace_rd, trace_data}, exp_q[0]);
      end
      trace_pop = 1'b1;
      cyc();
      void'(exp_q.pop_front());
    end
    // pop on an empty FIFO must be harmless
    trace_pop = 1'b1;
    cyc();
    trace_pop = 1'b0;
    checks++;
    if (trace_valid !== 1'b0 || trace_data !== '0) begin
      errors++;
      $display("FAIL %s_empty: valid=%b data=%h, want 0 0", name, trace_valid, trace_data);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    num_cycles = '0;
    cpu_rs1 = 5'd9;
    mon_rwe = 1'b0;
    mon_rd = '0;
    mon_data = '0;
    trace_pop = 1'b0;
    load_arrays(0);
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    checks++;
    if (cpu_reset !== 0 || test_mode !== 0 || busy !== 0 || done !== 0 || pass !== 0 ||
        error_count !== 0 || first_fail_reg !== 0 || trace_valid !== 0 ||
        trace_overflow !== 0 || exp_addr !== 0 || trace_cycle !== 0 || trace_rd !== 0 || trace_data !== 0) begin
      errors++;
      $display("FAIL reset_outputs: cpu_reset=%b test_mode=%b busy=%b done=%b pass=%b errs=%0d first=%0d valid=%b ovf=%b, want all 0",
               cpu_reset, test_mode, busy, done, pass, error_count, first_fail_reg, trace_valid, trace_overflow);
    end
    checks++;
    if (rs1_out !== 5'd9) begin
      errors++;
      $display("FAIL reset_rs1: rs1_out=%0d, want 9", rs1_out);
    end
    cpu_rs1 = 5'd22;
    #1;
    checks++;
    if (rs1_out !== 5'd22) begin
      errors++;
      $display("FAIL idle_rs1_mux: rs1_out=%0d, want 22", rs1_out);
    end
  endtask

  task automatic test_pass_run();
    load_arrays(0);
    random_plan(0);
    do_run(5, 1'b0);
    drain_trace("pass_run");
  endtask

  task automatic test_mismatch();
    load_arrays(0);
    rom[7]  = rom[7] ^ 32'h1;
    rom[20] = rom[20] ^ 32'h8000_00ff;
    clear_plan();
    do_run(3, 1'b0);
    checks++;
    if (error_count !== 6'd2 || first_fail_reg !== 5'd7 || pass !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_7_20: errs=%0d first=%0d pass=%b, want 2 7 0", error_count, first_fail_reg, pass);
    end
  endtask

  task automatic test_trace_order();
    load_arrays(0);
    clear_plan();
    plan_rwe[1] = 1'b1; plan_rd[1] = 5'd3; plan_data[1] = 32'd11;
    plan_rwe[2] = 1'b1; plan_rd[2] = 5'd3; plan_data[2] = 32'd12;
    plan_rwe[3] = 1'b1; plan_rd[3] = 5'd0; plan_data[3] = 32'd5;
    do_run(4, 1'b0);
    checks++;
    if (trace_cycle !== 10'd1 || trace_rd !== 5'd3 || trace_data !== 32'd11) begin
      errors++;
      $display("FAIL trace_first: head=(%0d,%0d,%0d), want (1,3,11)", trace_cycle, trace_rd, trace_data);
    end
    drain_trace("trace_order");
  endtask

  task automatic test_overflow();
    load_arrays(1);
    clear_plan();
    for (int k = 0; k < 7; k++) begin
      plan_rwe[k]  = 1'b1;
      plan_rd[k]   = AW'(k + 1);
      plan_data[k] = 32'h100 + k;
    end
    plan_pop[6] = 1'b1;   // push+pop while full
    do_run(8, 1'b0);
    checks++;
    if (trace_overflow !== 1'b1 || exp_q.size() != DEPTH) begin
      errors++;
      $display("FAIL overflow_flag: ovf=%b, want 1", trace_overflow);
    end
    drain_trace("overflow");
    checks++;
    if (trace_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: ovf=%b, want 1", trace_overflow);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      load_arrays($urandom_range(0, 3));
      random_plan($urandom_range(10, 60));
      do_run($urandom_range(1, 40), r[0]);
      drain_trace("random");
    end
  endtask

  task automatic test_zero_cycles();
    load_arrays(2);
    clear_plan();
    do_run(0, 1'b0);
  endtask

  task automatic test_reset_mid_scan();
    load_arrays(0);
    rom[2] = ~rom[2];
    clear_plan();
    plan_rwe[0] = 1'b1; plan_rd[0] = 5'd4; plan_data[0] = 32'habcd;
    start = 1'b1;
    num_cycles = 10'd3;
    cyc();
    start = 1'b0;
    mon_rwe = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      mon_rwe = plan_rwe[k]; mon_rd = plan_rd[k]; mon_data = plan_data[k];
      cyc();
    end
    mon_rwe = 1'b0;
    repeat (18) cyc();
    cpu_rs1 = 5'd30;
    checks++;
    if (test_mode !== 1'b1 || rs1_out !== 5'd9 || error_count !== 6'd1 || trace_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_scan_pre: test_mode=%b rs1_out=%0d errs=%0d valid=%b, want 1 9 1 1", test_mode, rs1_out, error_count, trace_valid);
    end
    reset = 1'b1;
    start = 1'b1;   // reset wins over start
    cyc();
    checks++;
    if (test_mode !== 0 || rs1_out !== 5'd30 || error_count !== 0 || trace_valid !== 0 ||
        busy !== 0 || done !== 0 || cpu_reset !== 0 || first_fail_reg !== 0 || exp_addr !== 0) begin
      errors++;
      $display("FAIL mid_scan_reset: test_mode=%b rs1_out=%0d errs=%0d valid=%b busy=%b done=%b, want 0 30 0 0 0 0",
               test_mode, rs1_out, error_count, trace_valid, busy, done);
    end
    reset = 1'b0;
    start = 1'b0;
    cyc();
    checks++;
    if (busy !== 1'b0 || cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_start: busy=%b cpu_reset=%b, want 0 0", busy, cpu_reset);
    end
  endtask

  initial begin
    test_reset();
    test_pass_run();
    test_mismatch();
    test_trace_order();
    test_overflow();
    test_random();
    test_zero_cycles();
    test_reset_mid_scan();
    test_pass_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
